apb_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single master-side port of apb_bridge between NUM_REQ independent requesters.
- Each requester presents one single-transfer command: wr, address, strb, data, dsel.
- The block latches the winning command, drives the one-cycle trnsfr pulse into the bridge, tracks the bridge ready handshake to completion, and returns read data and a done pulse to the owner.
- Sits between the system requesters and apb_bridge; apb_mem remains behind the bridge.

---
 rtl/apb_arb_pkg.sv | 54 +++++
 rtl/apb_rr_picker.sv | 31 +++
 rtl/apb_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB request arbiter.
// Widths follow the apb_arch.svh macros (ADDR_WIDTH, DATA_WIDTH, STRB_SIZE);
// the defaults below apply when that header has not been read first.
// Optional build macro: APB_ARB_TIMEOUT_EN (see apb_req_arbiter).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_SIZE
`define STRB_SIZE 4
`endif

package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic                   wr;
      logic [`ADDR_WIDTH-1:0] addr;
      logic [`DATA_WIDTH-1:0] wdata;
      logic [`STRB_SIZE-1:0]  strb;
      logic [1:0]             dsel;
   } apb_cmd_t;

   // Reference round-robin pick for up to 8 requesters: first set bit
   // searching upward from ptr, wrapping at n.
   function automatic logic [2:0] rr_pick(input logic [7:0]  valid,
                                          input logic [2:0]  ptr,
                                          input int unsigned n);
      logic [2:0]  win;
      logic        found;
      int unsigned j;
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (k < n && !found) begin
            j = (32'(ptr) + k) % n;
            if (valid[3'(j)]) begin
               win   = 3'(j);
               found = 1'b1;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the
// pointer sits at bit 0, priority-encode the lowest set bit, then add
// the pointer back (mod NUM_REQ) to get the absolute winner index.
module apb_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   off;
   logic [IDX_W:0]     sum;

   // Rotate, encode and unrotate in one combinational pass.
   always_comb begin
      rot = NUM_REQ'({valid, valid} >> ptr);
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      any = |valid;
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one apb_bridge master port among
// NUM_REQ requesters. FSM: IDLE -> ISSUE -> WAIT -> DRAIN -> IDLE.
// Optional build macro APB_ARB_TIMEOUT_EN adds a ready-wait timeout and
// the err output.
//
// Requester handshake: req_valid[i] is a level held with a stable command
// until req_grant[i] pulses for one cycle; at that edge the command is
// copied and the requester may drop or change its inputs. req_done[i]
// pulses once when the bridge transfer completes (req_rdata valid in that
// cycle for reads); req_valid[i] may be raised again the following cycle.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = `ADDR_WIDTH,
   parameter int DATA_W      = `DATA_WIDTH,
   parameter int STRB_W      = `STRB_SIZE,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*STRB_W-1:0] req_strb,
   input  logic [NUM_REQ*2-1:0]  req_dsel,
   output logic [NUM_REQ-1:0]    req_grant,
   output logic [NUM_REQ-1:0]    req_done,
   output logic [DATA_W-1:0]     req_rdata,
   output logic                  busy,
`ifdef APB_ARB_TIMEOUT_EN
   output logic                  err,
`endif
   output arb_state_e            dbg_state,
   output logic                  m_trnsfr,
   output logic                  m_wr,
   output logic [STRB_W-1:0]     m_strb,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [1:0]            m_dsel,
   input  logic                  m_ready,
   input  logic [DATA_W-1:0]     m_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e           state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, owner_q, pick_idx;
   logic                 pick_any;
   apb_cmd_t             cmd_q;
   logic [NUM_REQ-1:0]   grant_q, done_q, owner_oh;
   logic [DATA_W-1:0]    rdata_q;
   logic                 tmo_hit;

   apb_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid (req_valid),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   // Last WAIT cycle before giving up on the bridge.
   assign tmo_hit = (state_q == WAIT) && !m_ready &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Ready-wait counter: cleared on the way into WAIT, counts WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= tmo_hit;
         if (state_q == ISSUE)     tmo_cnt <= '0;
         else if (state_q == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign err = err_q;
`else
   assign tmo_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; m_ready is only looked at in WAIT and DRAIN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (m_ready) state_d = DRAIN;
                  else if (tmo_hit) state_d = IDLE;
         DRAIN:   if (!m_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Command latch, pointer, grant/done pulses and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
         cmd_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         rdata_q <= '0;
      end else begin
         grant_q <= '0;
         done_q  <= '0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  owner_q     <= pick_idx;
                  cmd_q.wr    <= req_wr[pick_idx];
                  cmd_q.addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                  cmd_q.wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                  cmd_q.strb  <= req_strb[pick_idx*STRB_W +: STRB_W];
                  cmd_q.dsel  <= req_dsel[pick_idx*2 +: 2];
                  grant_q     <= NUM_REQ'(1) << pick_idx;
                  ptr_q       <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                    : pick_idx + 1'b1;
               end
            end
            WAIT: begin
               if (m_ready)      rdata_q <= m_rdata;
               else if (tmo_hit) done_q  <= owner_oh;
            end
            DRAIN: begin
               if (!m_ready) done_q <= owner_oh;
            end
            default: ;
         endcase
      end
   end

   assign req_grant = grant_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;
   assign m_trnsfr  = (state_q == ISSUE);
   assign m_wr      = cmd_q.wr;
   assign m_addr    = cmd_q.addr;
   assign m_wdata   = cmd_q.wdata;
   assign m_strb    = cmd_q.strb;
   assign m_dsel    = cmd_q.dsel;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: a small bridge/memory stand-in answers each
// m_trnsfr with a ready pulse; expected grants, bridge commands and done
// responses are queued by the stimulus and consumed by a monitor.
module tb_apb_req_arbiter;
   import apb_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid, req_wr, req_grant, req_done;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_strb;
   logic [N*2-1:0]  req_dsel;
   logic [DW-1:0]   req_rdata, m_wdata, m_rdata;
   logic [AW-1:0]   m_addr;
   logic [SW-1:0]   m_strb;
   logic [1:0]      m_dsel;
   logic            busy, m_trnsfr, m_wr, m_ready, err_v;
   arb_state_e      dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   apb_req_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .req_dsel  (req_dsel),
      .req_grant (req_grant),
      .req_done  (req_done),
      .req_rdata (req_rdata),
      .busy      (busy),
`ifdef APB_ARB_TIMEOUT_EN
      .err       (err),
`endif
      .dbg_state (dbg_state),
      .m_trnsfr  (m_trnsfr),
      .m_wr      (m_wr),
      .m_strb    (m_strb),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_dsel    (m_dsel),
      .m_ready   (m_ready),
      .m_rdata   (m_rdata)
   );

`ifdef APB_ARB_TIMEOUT_EN
   logic err;
   assign err_v = err;
`else
   assign err_v = 1'b0;
`endif

   // ---------------- scoreboard state ----------------
   logic [N-1:0] exp_grant_q[$];
   logic [70:0]  exp_cmd_q[$];   // {wr, addr, wdata, strb, dsel}
   logic [36:0]  exp_done_q[$];  // {err, is_read, idx[2:0], rdata}
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           t_tr = 0;
   logic         prev_tr = 1'b0;
   logic         outstanding = 1'b0;
   logic [36:0]  e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- bridge + memory stand-in ----------------
   int          bridge_lat = 0;
   logic        bridge_en = 1'b1;
   logic [31:0] mem [256];
   logic        pend = 1'b0;
   int          bcnt = 0;
   logic        b_wr;
   logic [7:0]  b_addr;
   logic [31:0] b_wdata;

   initial begin
      m_ready = 1'b0;
      m_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend    = 1'b0;
            m_ready = 1'b0;
         end else begin
            if (m_ready) m_ready = 1'b0;
            else if (pend && bridge_en) begin
               if (bcnt == 0) begin
                  m_ready = 1'b1;
                  pend    = 1'b0;
                  if (b_wr) mem[b_addr] = b_wdata;
                  else      m_rdata = mem[b_addr];
               end else bcnt--;
            end
            if (m_trnsfr) begin
               pend    = 1'b1;
               bcnt    = bridge_lat;
               b_wr    = m_wr;
               b_addr  = m_addr[7:0];
               b_wdata = m_wdata;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (req_grant != '0) begin
               check("grant_while_busy", outstanding, 0);
               outstanding = 1'b1;
               if (exp_grant_q.size() == 0) check("grant_unexpected", req_grant, 0);
               else check("grant_order", req_grant, exp_grant_q.pop_front());
            end
            if (m_trnsfr) begin
               check("trnsfr_single", prev_tr, 0);
               if (exp_cmd_q.size() == 0) check("trnsfr_unexpected", m_trnsfr, 0);
               else check("bridge_cmd", {m_wr, m_addr, m_wdata, m_strb, m_dsel},
                          exp_cmd_q.pop_front());
               t_tr = cyc;
            end
            prev_tr = m_trnsfr;
            if (req_done != '0) begin
               outstanding = 1'b0;
               if (exp_done_q.size() == 0) check("done_unexpected", req_done, 0);
               else begin
                  e = exp_done_q.pop_front();
                  check("done_owner", req_done, 4'(1) << e[34:32]);
                  check("done_err", err_v, e[36]);
                  if (e[35]) check("read_data", req_rdata, e[31:0]);
                  if (e[36]) check("timeout_latency", cyc - t_tr, 65);
               end
            end else if (err_v) begin
               check("err_without_done", err_v, 0);
            end
         end else begin
            prev_tr     = 1'b0;
            outstanding = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [1:0] dsel);
      req_wr[i]              = wr;
      req_addr[i*AW +: AW]   = addr;
      req_wdata[i*DW +: DW]  = wdata;
      req_strb[i*SW +: SW]   = strb;
      req_dsel[i*2 +: 2]     = dsel;
   endtask

   task automatic push_xfer(input int i, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [1:0] dsel, input logic [31:0] exp_rd,
                            input logic exp_err);
      exp_grant_q.push_back(4'(1) << i);
      exp_cmd_q.push_back({wr, addr, wdata, strb, dsel});
      exp_done_q.push_back({exp_err, ~wr, 3'(i), exp_rd});
   endtask

   // Waits for n grants; non-held requesters drop valid on their grant,
   // everyone drops on the last one.
   task automatic wait_grants(input int n, input logic [N-1:0] hold);
      int got = 0;
      for (int c = 0; c < 3000 && got < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_grant[i]) begin
               got++;
               if (!hold[i]) req_valid[i] = 1'b0;
            end
         end
         if (got >= n) req_valid = '0;
      end
      check("grant_timeout", got, n);
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         @(negedge clk);
         if (exp_done_q.size() == 0 && !busy) ok = 1'b1;
      end
      check("idle_timeout", ok, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      req_valid = '0;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_dsel  = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {req_grant, req_done, req_rdata, busy, m_trnsfr, m_wr,
                              m_strb, m_addr, m_wdata, m_dsel, err_v, dbg_state}, 0);
      #1 rst_n = 1'b1;

      // Requester 0 writes 0x000A3210 to 0xF0.
      push_xfer(0, 1'b1, 32'hF0, 32'h000A3210, 4'hF, 2'd0, 32'h0, 1'b0);
      set_req(0, 1'b1, 32'hF0, 32'h000A3210, 4'hF, 2'd0);
      req_valid[0] = 1'b1;
      wait_grants(1, '0);
      wait_idle();
      check("mem_f0", mem[8'hF0], 32'h000A3210);

      // Requester 2 reads it back (pointer now 1, so 2 wins).
      bridge_lat = 2;
      push_xfer(2, 1'b0, 32'hF0, 32'h0, 4'h0, 2'd1, 32'h000A3210, 1'b0);
      set_req(2, 1'b0, 32'hF0, 32'h0, 4'h0, 2'd1);
      req_valid[2] = 1'b1;
      wait_grants(1, '0);
      wait_idle();

      // Reset again so the pointer starts at 0; all four write at once.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      bridge_lat = 1;
      for (int i = 0; i < N; i++) begin
         push_xfer(i, 1'b1, 32'hB0 + i, 32'h1000_0000 + i, 4'hF, 2'(i), 32'h0, 1'b0);
         set_req(i, 1'b1, 32'hB0 + i, 32'h1000_0000 + i, 4'hF, 2'(i));
      end
      req_valid = 4'hF;
      wait_grants(4, '0);
      wait_idle();

      // Requesters 1 and 3 held valid across six transfers: 1,3,1,3,1,3.
      bridge_lat = 0;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push_xfer(1, 1'b0, 32'hB1, 32'h0, 4'h0, 2'd2, 32'h1000_0001, 1'b0);
         else            push_xfer(3, 1'b0, 32'hB3, 32'h0, 4'h0, 2'd3, 32'h1000_0003, 1'b0);
      end
      set_req(1, 1'b0, 32'hB1, 32'h0, 4'h0, 2'd2);
      set_req(3, 1'b0, 32'hB3, 32'h0, 4'h0, 2'd3);
      req_valid = 4'b1010;
      wait_grants(6, 4'b1010);
      wait_idle();

      // Asynchronous reset while waiting on a slow bridge.
      bridge_lat = 20;
      push_xfer(0, 1'b1, 32'hC0, 32'h55, 4'hF, 2'd0, 32'h0, 1'b0);
      set_req(0, 1'b1, 32'hC0, 32'h55, 4'hF, 2'd0);
      req_valid[0] = 1'b1;
      wait_grants(1, '0);
      @(negedge clk);
      check("in_wait_before_reset", dbg_state, WAIT);
      set_req(0, 1'b1, 32'hC4, 32'h66, 4'hF, 2'd1);
      req_valid[0] = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs_async", {req_grant, req_done, req_rdata, busy, m_trnsfr, m_wr,
                                    m_strb, m_addr, m_wdata, m_dsel, err_v, dbg_state}, 0);
      exp_grant_q.delete();
      exp_cmd_q.delete();
      exp_done_q.delete();
      bridge_lat = 1;
      push_xfer(0, 1'b1, 32'hC4, 32'h66, 4'hF, 2'd1, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_grants(1, '0);
      wait_idle();
      check("mem_c4", mem[8'hC4], 32'h66);

`ifdef APB_ARB_TIMEOUT_EN
      // Bridge never answers: done + err after 64 WAIT cycles.
      bridge_en = 1'b0;
      push_xfer(2, 1'b1, 32'hD0, 32'h77, 4'hF, 2'd0, 32'h0, 1'b1);
      set_req(2, 1'b1, 32'hD0, 32'h77, 4'hF, 2'd0);
      req_valid[2] = 1'b1;
      wait_grants(1, '0);
      wait_idle();
      check("idle_after_timeout", dbg_state, IDLE);
`endif

      repeat (3) @(negedge clk);
      check("queues_drained", exp_grant_q.size() + exp_cmd_q.size() + exp_done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
